prefetch_buffer: RTL and testbench
==================================

# prefetch_buffer

Parametrised instruction prefetch unit that replaces single-slot fetch in the 5-stage RV32I pipeline. It sits between the instruction memory port and the decode stage and issues sequential PC requests ahead of decode. Returned words are held in a DEPTH-entry first-word-fall-through queue, and the queue is flushed with the fetch PC re-steered on a branch/jump redirect from execute. Any response still in flight when a redirect arrives is discarded.

## Interface
Parameters:
- XLEN, 32, PC/address width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- imem_request  output  1  read request to instruction memory
- imem_we_re  output  1  tied 0 (read)
- imem_mask  output  4  tied 4'b1111
- imem_address  output  XLEN  word address of current request
- imem_valid  input  1  one-cycle pulse: imem_rdata holds data for imem_address
- imem_rdata  input  32  instruction word
- redirect_en  input  1  taken branch / jal / jalr from execute
- redirect_pc  input  XLEN  new fetch target
- instr_valid  output  1  head entry available
- instr_ready  input  1  decode accepts head
- instr  output  32  head instruction
- instr_pc  output  XLEN  PC of head instruction
- count  output  $clog2(DEPTH+1)  entries held

## Operation
- Reset (rst=0, async) sets state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_request=0, imem_address=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if !redirect_en and count<DEPTH, then request fetch_pc and go to WAIT.
  - WAIT: imem_request=1, imem_address=fetch_pc, held stable until imem_valid. On imem_valid without redirect, push {fetch_pc, imem_rdata} and set fetch_pc+=4.
    - If count_next<DEPTH, stay in WAIT (back-to-back) with the new address.
    - Otherwise go to IDLE.
  - DISCARD: keep imem_request=1 at the abandoned address until imem_valid; drop that data, then go to IDLE.
- Redirect (highest priority, any state): queue cleared (count=0, pointers=0), fetch_pc<=redirect_pc with bits [1:0] forced to 0.
  - In WAIT without imem_valid: go to DISCARD.
  - In WAIT with imem_valid the same cycle: response dropped, go to IDLE.
  - In DISCARD: stay in DISCARD.
  - A pop in the redirect cycle has no effect beyond the flush.
- Pop: instr_valid & instr_ready advances the head. Simultaneous push and pop leaves count unchanged.
- Only one request is ever outstanding. Issue requires count<DEPTH, so a push never overflows, even when full-minus-one with a pop.
- fetch_pc arithmetic wraps modulo 2^XLEN. Queue pointers wrap modulo DEPTH.

## Timing
- instr_valid = (count!=0), registered-derived. instr/instr_pc read combinationally from the head slot (FWFT).
- Redirect in cycle N: instr_valid=0 in N+1. The request to redirect_pc is visible in N+1 from IDLE, or after the discard completes.
- Response accepted in cycle M into an empty queue: instr_valid=1 in M+1.
- With zero-wait memory (imem_valid the cycle after address change), sustained rate is 1 word/cycle until full.
- Full queue: imem_request drops the cycle after the filling push and re-asserts the cycle after the first pop.
- Reset mid-request: the in-flight response is lost. The memory side shares the reset.

## Structure
- core_pkg: fetch_state_t enum (IDLE, WAIT, DISCARD), INSTR_W=32, RV_NOP=32'h0000_0013.
- Sub-module fetch_fifo: parametrised DEPTH×(32+XLEN) FWFT storage with push/pop/flush/count. The FSM and PC logic live in prefetch_buffer.

## Test plan
- Reset, imem zero-wait returning 0x0000_0013 + addr, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8 on consecutive cycles; first instr_valid 2 cycles after reset release.
- instr_ready=0, DEPTH=4 -> count reaches 4, imem_request=0, no further addresses. One pop -> request at 0x10 the next cycle.
- redirect_en with redirect_pc=0x100 while WAIT at 0x20 with imem_valid delayed 3 cycles -> 0x20 data never appears. Next request is 0x100. First instr_pc=0x100.
- redirect_en in the same cycle as imem_valid -> data dropped, queue empty, request 0x100 next cycle.
- redirect_pc=0x103 -> fetch at 0x100. redirect_pc=0xFFFF_FFFC -> following address 0x0000_0000.
- Assert rst low mid-WAIT with count=3 -> all outputs at reset values immediately (async). Restart fetch from RESET_PC.

Source files
------------

// File: rtl/prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/prefetch_buffer_if.sv
// Instruction-memory, redirect and decode-side signals of the prefetch unit.
interface prefetch_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);

    logic                         imem_request;
    logic                         imem_we_re;
    logic [3:0]                   imem_mask;
    logic [XLEN-1:0]              imem_address;
    logic                         imem_valid;
    logic [31:0]                  imem_rdata;
    logic                         redirect_en;
    logic [XLEN-1:0]              redirect_pc;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [31:0]                  instr;
    logic [XLEN-1:0]              instr_pc;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output imem_request,
        output imem_we_re,
        output imem_mask,
        output imem_address,
        input  imem_valid,
        input  imem_rdata,
        input  redirect_en,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output count
    );

    modport slave (
        input  imem_request,
        input  imem_we_re,
        input  imem_mask,
        input  imem_address,
        output imem_valid,
        output imem_rdata,
        output redirect_en,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  count
    );

endinterface

// File: rtl/prefetch_buffer_fifo.sv
// First-word-fall-through queue of {pc, instruction} entries with synchronous flush.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = i_push & ~i_flush;
    assign w_rd = i_pop & ~i_flush;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding imem read, FWFT queue toward decode,
// flush and re-steer on redirect with discard of any in-flight response.
module prefetch_buffer
    import core_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    prefetch_buffer_if.master bus
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH+1);
    localparam int unsigned      ENTRY_W = XLEN + INSTR_W;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    w_fetch_pc_next;
    logic [XLEN-1:0]    r_discard_addr;
    logic [XLEN-1:0]    w_discard_addr_next;
    logic               r_live;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_instr_valid;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [ENTRY_W-1:0] w_head;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  ({r_fetch_pc, bus.imem_rdata}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign w_instr_valid = (w_count != '0);
    assign w_flush       = bus.redirect_en;
    assign w_pop         = w_instr_valid & bus.instr_ready & ~bus.redirect_en;

    always_comb begin
        w_state_next        = r_state;
        w_fetch_pc_next     = r_fetch_pc;
        w_discard_addr_next = r_discard_addr;
        w_req               = 1'b0;
        w_push              = 1'b0;

        unique case (r_state)
            IDLE: begin
                // An issued request is visible this cycle, so a same-cycle response is kept.
                w_req  = r_live & ~bus.redirect_en & (w_count < FULL);
                w_push = w_req & bus.imem_valid;
                if (w_req) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_req  = 1'b1;
                w_push = bus.imem_valid & ~bus.redirect_en;
                if (bus.redirect_en) begin
                    w_state_next = bus.imem_valid ? IDLE : DISCARD;
                    if (!bus.imem_valid) begin
                        w_discard_addr_next = r_fetch_pc;
                    end
                end
            end
            DISCARD: begin
                w_req = 1'b1;
                if (bus.imem_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + XLEN'(4);
            w_state_next    = (w_count_next < FULL) ? WAIT : IDLE;
        end
        if (bus.redirect_en) begin
            w_fetch_pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    // r_live keeps the request low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_fetch_pc     <= RESET_PC;
            r_discard_addr <= RESET_PC;
            r_live         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_fetch_pc     <= w_fetch_pc_next;
            r_discard_addr <= w_discard_addr_next;
            r_live         <= 1'b1;
        end
    end

    assign bus.imem_request = w_req;
    assign bus.imem_we_re   = 1'b0;
    assign bus.imem_mask    = 4'b1111;
    assign bus.imem_address = (r_state == DISCARD) ? r_discard_addr : r_fetch_pc;
    assign bus.instr_valid  = w_instr_valid;
    assign bus.instr        = w_instr_valid ? w_head[INSTR_W-1:0] : '0;
    assign bus.instr_pc     = w_instr_valid ? w_head[ENTRY_W-1:INSTR_W] : '0;
    assign bus.count        = w_count;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_prefetch_buffer;
    import core_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prefetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    prefetch_buffer #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: words held by the queue, next sequential fetch, pending/discard state.
    logic [31:0] q[$];
    logic [31:0] nxt;
    logic [31:0] disc_addr;
    bit          disc;
    bit          outst;
    bit          live;

    // Memory model: responds after m_lat cycles of a request held at one address.
    bit          m_busy;
    logic [31:0] m_addr;
    int          m_held;
    int          m_lat;
    int          mem_lat;
    bit          rand_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b0;
        bus.redirect_en     = 1'b0;
        bus.redirect_pc     = '0;
        bus.instr_ready     = 1'b0;
        bus.imem_valid      = 1'b0;
        bus.imem_rdata      = '0;
        #1;
        chk("rst_req",   32'(bus.imem_request), 32'd0);
        chk("rst_addr",  bus.imem_address, RESET_PC);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc",    bus.instr_pc, 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        q.delete();
        nxt    = RESET_PC;
        disc   = 1'b0;
        outst  = 1'b0;
        live   = 1'b0;
        m_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit redir_i, input logic [31:0] rpc, input bit ready,
                         input bit redir_on_valid);
        bit mv;
        bit req_e;
        bit acc;
        bit pop;
        bit disc_old;
        bit redir;
        redir           = redir_i;
        bus.redirect_en = redir;
        bus.redirect_pc = rpc;
        bus.instr_ready = ready;
        #1;
        if (bus.imem_request) begin
            if (!m_busy || bus.imem_address != m_addr) begin
                m_busy = 1'b1;
                m_addr = bus.imem_address;
                m_held = 0;
                m_lat  = rand_lat ? int'($urandom_range(0, 2)) : mem_lat;
            end
            mv = (m_held >= m_lat);
        end else begin
            m_busy = 1'b0;
            mv     = 1'b0;
        end
        bus.imem_valid = mv;
        bus.imem_rdata = mv ? RV_NOP + m_addr : 32'hDEAD_BEEF;
        if (redir_on_valid && mv) begin
            redir           = 1'b1;
            bus.redirect_en = 1'b1;
        end
        #1;
        req_e = live && (disc || outst || (!redir && q.size() < DEPTH));
        chk("req", 32'(bus.imem_request), 32'(req_e));
        if (req_e) begin
            chk("addr", bus.imem_address, disc ? disc_addr : nxt);
        end
        chk("valid", 32'(bus.instr_valid), 32'(q.size() != 0));
        chk("count", 32'(bus.count), 32'(q.size()));
        if (q.size() != 0) begin
            chk("pc", bus.instr_pc, q[0]);
            chk("instr", bus.instr, RV_NOP + q[0]);
        end
        disc_old = disc;
        pop      = (q.size() != 0) && ready && !redir;
        acc      = req_e && mv && !disc_old && !redir;
        if (redir) begin
            if (disc_old) begin
                disc = !mv;
            end else if (req_e && !mv) begin
                disc      = 1'b1;
                disc_addr = nxt;
            end
            q.delete();
            nxt   = {rpc[31:2], 2'b00};
            outst = 1'b0;
        end else begin
            if (disc_old && mv) disc = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(nxt);
                nxt = nxt + 32'd4;
            end
            outst = acc ? (q.size() < DEPTH) : (req_e && !mv && !disc_old);
        end
        @(posedge clk);
        if (m_busy) begin
            if (mv) m_busy = 1'b0;
            else m_held++;
        end
        live = 1'b1;
        #1;
        bus.redirect_en = 1'b0;
        bus.imem_valid  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit got;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        bus.imem_valid  = 1'b0;
        bus.imem_rdata  = '0;
        rand_lat        = 1'b0;
        mem_lat         = 0;
        #2;

        // Zero-wait streaming from reset.
        do_reset();
        chk("we_re", 32'(bus.imem_we_re), 32'd0);
        chk("mask",  32'(bus.imem_mask), 32'hF);
        cycle(0, 0, 1, 0);
        chk("t1_valid_c1", 32'(bus.instr_valid), 32'd0);
        cycle(0, 0, 1, 0);
        chk("t1_valid_c2", 32'(bus.instr_valid), 32'd1);
        chk("t1_pc0", bus.instr_pc, 32'h0);
        cycle(0, 0, 1, 0);
        chk("t1_pc1", bus.instr_pc, 32'h4);
        cycle(0, 0, 1, 0);
        chk("t1_pc2", bus.instr_pc, 32'h8);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // Fill with decode stalled, then a single pop reopens fetch at 0x10.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
        chk("t2_full_count", 32'(bus.count), 32'd4);
        chk("t2_full_noreq", 32'(bus.imem_request), 32'd0);
        cycle(0, 0, 1, 0);
        chk("t2_reissue_req",  32'(bus.imem_request), 32'd1);
        chk("t2_reissue_addr", bus.imem_address, 32'h10);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Redirect while a slow response to 0x20 is pending.
        cycle(1, 32'h20, 1, 0);
        mem_lat = 3;
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 32'h100, 1, 0);
        mem_lat = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(0, 0, 1, 0);
            if (bus.instr_valid) got = 1'b1;
        end
        chk("t3_seen", 32'(got), 32'd1);
        chk("t3_pc",   bus.instr_pc, 32'h100);

        // Redirect coinciding with the response.
        mem_lat = 2;
        cycle(1, 32'h40, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 32'h100, 1, 1);
        chk("t4_count", 32'(bus.count), 32'd0);
        chk("t4_req",   32'(bus.imem_request), 32'd1);
        chk("t4_addr",  bus.imem_address, 32'h100);

        // Misaligned target and address wrap.
        mem_lat = 0;
        cycle(1, 32'h103, 1, 0);
        chk("t5_align", bus.imem_address, 32'h100);
        cycle(1, 32'hFFFF_FFFC, 1, 0);
        cycle(0, 0, 1, 0);
        chk("t5_wrap", bus.imem_address, 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // Randomized traffic.
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 11) == 0));
        end

        // Asynchronous reset while waiting with three entries held.
        rand_lat = 1'b0;
        mem_lat  = 3;
        do_reset();
        for (int i = 0; i < 40 && q.size() != 3; i++) cycle(0, 0, 0, 0);
        chk("t7_pre_count", 32'(bus.count), 32'd3);
        chk("t7_pre_req",   32'(bus.imem_request), 32'd1);
        do_reset();
        mem_lat = 0;
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
